// File: rtl/bpu_update_if.sv
// Resolved-branch input and predictor write-port bundle for bpu_update.
// The slave side is the update unit; the master side is backend plus frontend.
interface bpu_update_if #(
    parameter int DEPTH = 4
);
    localparam int PW = $clog2(DEPTH) + 1;

    logic          res_valid;
    logic          res_ready;
    logic [63:0]   res_pc;
    logic          res_taken;
    logic [63:0]   res_target;
    logic [31:0]   res_bht_data;
    logic [31:0]   res_btb_data;
    logic          rd_busy;
    logic          wr_en;
    logic [63:0]   wr_addr;
    logic [31:0]   bht_wr_data;
    logic [31:0]   btb_wr_data;
    logic [PW-1:0] pending;

    modport master (
        output res_valid, res_pc, res_taken, res_target, res_bht_data, res_btb_data, rd_busy,
        input  res_ready, wr_en, wr_addr, bht_wr_data, btb_wr_data, pending
    );

    modport slave (
        input  res_valid, res_pc, res_taken, res_target, res_bht_data, res_btb_data, rd_busy,
        output res_ready, wr_en, wr_addr, bht_wr_data, btb_wr_data, pending
    );
endinterface

// File: rtl/bpu_update.sv
// Branch-predictor update unit: turns resolved branches into BHT/BTB words,
// queues them in a small FIFO and drains one write per idle array cycle.
module bpu_update #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    bpu_update_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL = PW'(DEPTH);

    logic [63:0]   addrMem_q [DEPTH];
    logic [31:0]   bhtMem_q  [DEPTH];
    logic [31:0]   btbMem_q  [DEPTH];
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] count_q, count_d;

    logic [AW-1:0] fwdIdx;
    logic [31:0]   baseBht, baseBtb;
    logic [4:0]    slot;
    logic [1:0]    oldCtr, newCtr;
    logic [31:0]   newBht, newBtb;
    logic          redundant, push, pop, headValid;
    logic          unusedTargetHi;

    assign unusedTargetHi = ^bus.res_target[63:32];

    // Youngest queued entry for the same PC wins; the head counts even when it pops this edge.
    always_comb begin
        baseBht = bus.res_bht_data;
        baseBtb = bus.res_btb_data;
        fwdIdx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwdIdx = rdPtr_q + AW'(k);
            if ((PW'(k) < count_q) && (addrMem_q[fwdIdx] == bus.res_pc)) begin
                baseBht = bhtMem_q[fwdIdx];
                baseBtb = btbMem_q[fwdIdx];
            end
        end
    end

    always_comb begin
        slot   = {bus.res_pc[5:2], 1'b0};
        oldCtr = baseBht[slot +: 2];
        newCtr = oldCtr;
        if (bus.res_taken) begin
            if (oldCtr != 2'd3) newCtr = oldCtr + 2'd1;
        end else begin
            if (oldCtr != 2'd0) newCtr = oldCtr - 2'd1;
        end
        newBht = baseBht;
        newBht[slot +: 2] = newCtr;
        newBtb = bus.res_taken ? bus.res_target[31:0] : baseBtb;
    end

    // Unaligned PCs and no-change updates complete the handshake but never enqueue.
    assign redundant     = (newBht == baseBht) && (newBtb == baseBtb);
    assign bus.res_ready = (count_q != FULL);
    assign push          = bus.res_valid && bus.res_ready && !bus.res_pc[2] && !redundant;

    assign headValid       = (count_q != '0) && !reset;
    assign pop             = headValid && !bus.rd_busy;
    assign bus.wr_en       = pop;
    assign bus.wr_addr     = headValid ? addrMem_q[rdPtr_q] : 64'd0;
    assign bus.bht_wr_data = headValid ? bhtMem_q[rdPtr_q]  : 32'd0;
    assign bus.btb_wr_data = headValid ? btbMem_q[rdPtr_q]  : 32'd0;
    assign bus.pending     = count_q;

    always_comb begin
        rdPtr_d = pop  ? rdPtr_q + AW'(1) : rdPtr_q;
        wrPtr_d = push ? wrPtr_q + AW'(1) : wrPtr_q;
        count_d = count_q;
        if (push && !pop) count_d = count_q + PW'(1);
        if (pop && !push) count_d = count_q - PW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !reset) begin
            addrMem_q[wrPtr_q] <= bus.res_pc;
            bhtMem_q[wrPtr_q]  <= newBht;
            btbMem_q[wrPtr_q]  <= newBtb;
        end
    end
endmodule

// File: tb/tb_bpu_update.sv
// Scenario bench for bpu_update: expected writes are queued as records are
// driven and compared in order whenever the unit strobes wr_en.
module tb_bpu_update;
    localparam int DEPTH = 4;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] bht;
        logic [31:0] btb;
    } wrRec_t;

    logic   clock = 1'b0;
    logic   reset;
    int     total = 0;
    int     bad   = 0;
    wrRec_t sbQ[$];

    always #5 clock = ~clock;

    bpu_update_if #(.DEPTH(DEPTH)) bus ();

    bpu_update #(.DEPTH(DEPTH)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // Every array write must match the oldest outstanding expectation.
    always @(negedge clock) begin
        wrRec_t exp;
        if (bus.wr_en === 1'b1) begin
            total++;
            if (sbQ.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_write: got addr=%h bht=%h btb=%h, required no write",
                         bus.wr_addr, bus.bht_wr_data, bus.btb_wr_data);
            end else begin
                exp = sbQ.pop_front();
                if (bus.wr_addr !== exp.addr || bus.bht_wr_data !== exp.bht || bus.btb_wr_data !== exp.btb) begin
                    bad++;
                    $display("[TB] FAIL write_data: got addr=%h bht=%h btb=%h, required addr=%h bht=%h btb=%h",
                             bus.wr_addr, bus.bht_wr_data, bus.btb_wr_data, exp.addr, exp.bht, exp.btb);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expectWrite(input logic [63:0] addr, input logic [31:0] bht, input logic [31:0] btb);
        wrRec_t rec;
        rec.addr = addr;
        rec.bht  = bht;
        rec.btb  = btb;
        sbQ.push_back(rec);
    endtask

    // Presents one record and holds it until accepted (bounded).
    task automatic applyStimulus(input logic [63:0] pc, input logic taken, input logic [63:0] target,
                                 input logic [31:0] bht, input logic [31:0] btb);
        int waitCycles = 0;
        bus.res_pc       = pc;
        bus.res_taken    = taken;
        bus.res_target   = target;
        bus.res_bht_data = bht;
        bus.res_btb_data = btb;
        bus.res_valid    = 1'b1;
        @(negedge clock);
        while (bus.res_ready !== 1'b1 && waitCycles < 20) begin
            @(negedge clock);
            waitCycles++;
        end
        if (bus.res_ready !== 1'b1) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: res_ready=%b, required 1 within 20 cycles", bus.res_ready);
        end
        tick();
        bus.res_valid = 1'b0;
    endtask

    task automatic waitEmpty();
        int n = 0;
        while (sbQ.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        repeat (2) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clock);
        total += 6;
        if (bus.res_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b, required 1", bus.res_ready); end
        if (bus.wr_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_wr_en: got %b, required 0", bus.wr_en); end
        if (bus.pending !== 3'd0) begin bad++; $display("[TB] FAIL reset_pending: got %0d, required 0", bus.pending); end
        if (bus.wr_addr !== 64'd0) begin bad++; $display("[TB] FAIL reset_wr_addr: got %h, required 0", bus.wr_addr); end
        if (bus.bht_wr_data !== 32'd0) begin bad++; $display("[TB] FAIL reset_bht: got %h, required 0", bus.bht_wr_data); end
        if (bus.btb_wr_data !== 32'd0) begin bad++; $display("[TB] FAIL reset_btb: got %h, required 0", bus.btb_wr_data); end
        tick();
    endtask

    task automatic test_single_taken();
        expectWrite(64'h8000_0010, 32'h0000_0100, 32'h8000_0100);
        applyStimulus(64'h8000_0010, 1'b1, 64'h8000_0100, 32'd0, 32'd0);
        @(negedge clock);
        total += 2;
        if (bus.wr_en !== 1'b1) begin bad++; $display("[TB] FAIL single_wr_en: got %b, required 1", bus.wr_en); end
        if (bus.pending !== 3'd1) begin bad++; $display("[TB] FAIL single_pending: got %0d, required 1", bus.pending); end
        tick();
        @(negedge clock);
        total += 2;
        if (bus.pending !== 3'd0) begin bad++; $display("[TB] FAIL single_drained: got %0d, required 0", bus.pending); end
        if (bus.wr_en !== 1'b0) begin bad++; $display("[TB] FAIL single_idle: got %b, required 0", bus.wr_en); end
        waitEmpty();
    endtask

    task automatic test_saturation();
        applyStimulus(64'h8000_0000, 1'b1, 64'h0000_0000_1234_5678, 32'h0000_0003, 32'h1234_5678);
        @(negedge clock);
        total++;
        if (bus.pending !== 3'd0) begin bad++; $display("[TB] FAIL sat_taken_filter: pending=%0d, required 0", bus.pending); end
        tick();
        applyStimulus(64'h8000_0000, 1'b0, 64'h0000_0000_0000_FFFF, 32'hFFFF_FFFC, 32'h0000_CAFE);
        @(negedge clock);
        total++;
        if (bus.pending !== 3'd0) begin bad++; $display("[TB] FAIL sat_ntaken_filter: pending=%0d, required 0", bus.pending); end
        tick();
        expectWrite(64'h8000_0000, 32'hFFFF_FFFE, 32'h0000_00AA);
        applyStimulus(64'h8000_0000, 1'b0, 64'h0000_0000_0000_0999, 32'hFFFF_FFFF, 32'h0000_00AA);
        expectWrite(64'h8000_0028, 32'h0020_0000, 32'hDEAD_BEE0);
        applyStimulus(64'h8000_0028, 1'b1, 64'h0000_0001_DEAD_BEE0, 32'h0010_0000, 32'h0000_0011);
        expectWrite(64'h8000_0030, 32'h0300_0000, 32'h0000_0002);
        applyStimulus(64'h8000_0030, 1'b1, 64'h0000_0000_0000_0002, 32'h0300_0000, 32'h0000_0001);
        waitEmpty();
        total++;
        if (sbQ.size() != 0) begin bad++; $display("[TB] FAIL sat_drain: outstanding=%0d, required 0", sbQ.size()); end
    endtask

    task automatic test_unaligned();
        applyStimulus(64'h8000_0004, 1'b1, 64'h0000_0000_0000_0100, 32'd0, 32'd0);
        @(negedge clock);
        total += 2;
        if (bus.pending !== 3'd0) begin bad++; $display("[TB] FAIL unaligned_pending: got %0d, required 0", bus.pending); end
        if (bus.res_ready !== 1'b1) begin bad++; $display("[TB] FAIL unaligned_ready: got %b, required 1", bus.res_ready); end
        repeat (3) tick();
    endtask

    task automatic test_backpressure();
        logic [63:0] pc;
        bus.rd_busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            pc = 64'h8000_1000 + 64'(k) * 64'h48;
            expectWrite(pc, 32'h1 << (2 * int'(pc[5:2])), 32'h9000_0000 + 32'(k));
            applyStimulus(pc, 1'b1, 64'h9000_0000 + 64'(k), 32'd0, 32'd0);
        end
        @(negedge clock);
        total += 2;
        if (bus.pending !== 3'd4) begin bad++; $display("[TB] FAIL bp_full_pending: got %0d, required 4", bus.pending); end
        if (bus.res_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_full_ready: got %b, required 0", bus.res_ready); end
        tick();
        expectWrite(64'h8000_2000, 32'h0000_0001, 32'h0000_0055);
        bus.res_pc       = 64'h8000_2000;
        bus.res_taken    = 1'b0;
        bus.res_target   = 64'h0;
        bus.res_bht_data = 32'h0000_0002;
        bus.res_btb_data = 32'h0000_0055;
        bus.res_valid    = 1'b1;
        tick();
        @(negedge clock);
        total++;
        if (bus.pending !== 3'd4) begin bad++; $display("[TB] FAIL bp_held: pending=%0d, required 4", bus.pending); end
        tick();
        bus.rd_busy = 1'b0;
        @(negedge clock);
        total += 2;
        if (bus.wr_en !== 1'b1) begin bad++; $display("[TB] FAIL bp_first_pop: wr_en=%b, required 1", bus.wr_en); end
        if (bus.res_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_no_credit: ready=%b, required 0", bus.res_ready); end
        tick();
        @(negedge clock);
        total += 2;
        if (bus.res_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_ready_back: ready=%b, required 1", bus.res_ready); end
        if (bus.wr_en !== 1'b1) begin bad++; $display("[TB] FAIL bp_second_pop: wr_en=%b, required 1", bus.wr_en); end
        tick();
        bus.res_valid = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clock);
            total++;
            if (bus.wr_en !== 1'b1) begin bad++; $display("[TB] FAIL bp_consecutive_%0d: wr_en=%b, required 1", n, bus.wr_en); end
            tick();
        end
        waitEmpty();
        total += 2;
        if (sbQ.size() != 0) begin bad++; $display("[TB] FAIL bp_drain: outstanding=%0d, required 0", sbQ.size()); end
        if (bus.pending !== 3'd0) begin bad++; $display("[TB] FAIL bp_empty: pending=%0d, required 0", bus.pending); end
    endtask

    task automatic test_forwarding();
        bus.rd_busy = 1'b1;
        expectWrite(64'h8000_0000, 32'h0000_0001, 32'h8000_0000);
        applyStimulus(64'h8000_0000, 1'b1, 64'h8000_0000, 32'd0, 32'd0);
        expectWrite(64'h8000_0000, 32'h0000_0002, 32'h8000_0000);
        applyStimulus(64'h8000_0000, 1'b1, 64'h8000_0000, 32'd0, 32'd0);
        @(negedge clock);
        total++;
        if (bus.pending !== 3'd2) begin bad++; $display("[TB] FAIL fwd_queued: pending=%0d, required 2", bus.pending); end
        tick();
        bus.rd_busy = 1'b0;
        waitEmpty();
        total++;
        if (sbQ.size() != 0) begin bad++; $display("[TB] FAIL fwd_drain: outstanding=%0d, required 0", sbQ.size()); end
    endtask

    task automatic test_back_to_back();
        bus.rd_busy = 1'b0;
        expectWrite(64'h8000_0100, 32'h0000_0001, 32'h8000_0200);
        applyStimulus(64'h8000_0100, 1'b1, 64'h8000_0200, 32'd0, 32'd0);
        expectWrite(64'h8000_0100, 32'h0000_0002, 32'h8000_0200);
        applyStimulus(64'h8000_0100, 1'b1, 64'h8000_0200, 32'd0, 32'd0);
        waitEmpty();
        total++;
        if (sbQ.size() != 0) begin bad++; $display("[TB] FAIL b2b_drain: outstanding=%0d, required 0", sbQ.size()); end
    endtask

    task automatic test_reset_mid_drain();
        bus.rd_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            expectWrite(64'h8000_3000 + 64'(k) * 64'h40, 32'h0000_0001, 32'h7000_0000 + 32'(k));
            applyStimulus(64'h8000_3000 + 64'(k) * 64'h40, 1'b1, 64'h7000_0000 + 64'(k), 32'd0, 32'd0);
        end
        @(negedge clock);
        total++;
        if (bus.pending !== 3'd3) begin bad++; $display("[TB] FAIL rst_queued: pending=%0d, required 3", bus.pending); end
        tick();
        reset = 1'b1;
        bus.rd_busy = 1'b0;
        sbQ.delete();
        @(negedge clock);
        total++;
        if (bus.wr_en !== 1'b0) begin bad++; $display("[TB] FAIL rst_cycle_wr_en: got %b, required 0", bus.wr_en); end
        tick();
        reset = 1'b0;
        @(negedge clock);
        total += 2;
        if (bus.pending !== 3'd0) begin bad++; $display("[TB] FAIL rst_pending: got %0d, required 0", bus.pending); end
        if (bus.wr_en !== 1'b0) begin bad++; $display("[TB] FAIL rst_after_wr_en: got %b, required 0", bus.wr_en); end
        tick();
        expectWrite(64'h8000_0008, 32'h0000_0010, 32'h8000_0800);
        applyStimulus(64'h8000_0008, 1'b1, 64'h8000_0800, 32'd0, 32'd0);
        waitEmpty();
        total++;
        if (sbQ.size() != 0) begin bad++; $display("[TB] FAIL rst_recover: outstanding=%0d, required 0", sbQ.size()); end
    endtask

    initial begin
        reset            = 1'b1;
        bus.res_valid    = 1'b0;
        bus.res_pc       = 64'd0;
        bus.res_taken    = 1'b0;
        bus.res_target   = 64'd0;
        bus.res_bht_data = 32'd0;
        bus.res_btb_data = 32'd0;
        bus.rd_busy      = 1'b0;

        test_reset();
        test_single_taken();
        test_saturation();
        test_unaligned();
        test_backpressure();
        test_forwarding();
        test_back_to_back();
        test_reset_mid_drain();

        repeat (3) tick();
        total++;
        if (sbQ.size() != 0) begin bad++; $display("[TB] FAIL final_outstanding: got %0d, required 0", sbQ.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
